// File: rtl/snn_readout_pkg.sv
// Shared types and constants for the SNN spike readout: FSM state encoding,
// default spike-counter width and the total-spike accumulator width.
package snn_readout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_CW = 8;
  localparam int TOTAL_W    = 16;

endpackage : snn_readout_pkg

// File: rtl/snn_argmax_scan.sv
// Serial argmax: one (index, count) pair is offered per enabled cycle and the
// running best is replaced only on a strictly larger count.
module snn_argmax_scan
  import snn_readout_pkg::*;
#(
  parameter int N  = 96,
  parameter int CW = DEFAULT_CW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [$clog2(N)-1:0] idx_i,
  input  logic [CW-1:0]        count_i,
  // Best so far including the pair offered this cycle.
  output logic [$clog2(N)-1:0] best_idx_o,
  output logic [CW-1:0]        best_count_o
);

  logic [$clog2(N)-1:0] best_idx_q, best_idx_d;
  logic [CW-1:0]        best_count_q, best_count_d;

  // NOTE: every always_comb output gets a default first; a path that leaves
  // it unassigned would infer a latch.
  always_comb begin
    best_idx_d   = best_idx_q;
    best_count_d = best_count_q;
    if (en_i && (count_i > best_count_q)) begin
      best_idx_d   = idx_i;
      best_count_d = count_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      best_idx_q   <= '0;
      best_count_q <= '0;
    end else if (clear_i) begin
      best_idx_q   <= '0;
      best_count_q <= '0;
    end else begin
      best_idx_q   <= best_idx_d;
      best_count_q <= best_count_d;
    end
  end

  assign best_idx_o   = best_idx_d;
  assign best_count_o = best_count_d;

endmodule : snn_argmax_scan

// File: rtl/snn_spike_readout.sv
// Window-based spike readout: counts spikes per neuron over win_len steps, then
// serially picks the winner. Define SNN_READOUT_TOTAL_EN for a total-spike count.
module snn_spike_readout
  import snn_readout_pkg::*;
#(
  parameter int N  = 96,
  parameter int CW = DEFAULT_CW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [15:0]          win_len,
  input  logic                 step_valid,
  input  logic [N-1:0]         spikes_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] class_idx,
  output logic [CW-1:0]        class_count,
  output logic                 out_empty,
  output logic                 busy,
  output logic [TOTAL_W-1:0]   total_count
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        state_q;
  logic [15:0]   win_q;
  logic [15:0]   step_cnt_q;
  logic [IW-1:0] scan_idx_q;
  logic [CW-1:0] cnt_q [N];
  logic          out_valid_q;
  logic [IW-1:0] class_idx_q;
  logic [CW-1:0] class_count_q;
  logic          out_empty_q;

  logic          clear;
  logic          accept;
  logic          last_step;
  logic          scan_en;
  logic          last_scan;
  logic [IW-1:0] best_idx_d;
  logic [CW-1:0] best_count_d;

  assign clear     = (state_q == IDLE) && start;
  assign accept    = (state_q == ACCUM) && step_valid;
  assign last_step = accept && ((step_cnt_q + 16'd1) == win_q);
  assign scan_en   = (state_q == SCAN);
  assign last_scan = scan_en && (scan_idx_q == LAST_IDX);

  // NOTE: the counter array is held in flops (not RAM) so it can take the
  // asynchronous reset; an abort mid-window must leave no stale counts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < N; n++) cnt_q[n] <= '0;
    end else if (clear) begin
      for (int n = 0; n < N; n++) cnt_q[n] <= '0;
    end else if (accept) begin
      for (int n = 0; n < N; n++) begin
        if (spikes_vec[n] && (cnt_q[n] != CNT_MAX)) cnt_q[n] <= cnt_q[n] + CW'(1);
      end
    end
  end

  snn_argmax_scan #(
    .N  (N),
    .CW (CW)
  ) u_argmax (
    .clk          (clk),
    .rstn         (rstn),
    .clear_i      (clear),
    .en_i         (scan_en),
    .idx_i        (scan_idx_q),
    .count_i      (cnt_q[scan_idx_q]),
    .best_idx_o   (best_idx_d),
    .best_count_o (best_count_d)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      win_q         <= 16'd1;
      step_cnt_q    <= '0;
      scan_idx_q    <= '0;
      out_valid_q   <= 1'b0;
      class_idx_q   <= '0;
      class_count_q <= '0;
      out_empty_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            win_q      <= (win_len == 16'd0) ? 16'd1 : win_len;
            step_cnt_q <= '0;
            scan_idx_q <= '0;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (step_valid) begin
            step_cnt_q <= step_cnt_q + 16'd1;
            if (last_step) state_q <= SCAN;
          end
        end
        SCAN: begin
          scan_idx_q <= scan_idx_q + IW'(1);
          // The last visit's comparison result is latched straight into the
          // output registers, so out_valid rises exactly N edges after the
          // final step.
          if (last_scan) begin
            scan_idx_q    <= '0;
            state_q       <= DONE;
            out_valid_q   <= 1'b1;
            class_idx_q   <= best_idx_d;
            class_count_q <= best_count_d;
            out_empty_q   <= (best_count_d == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign class_idx   = class_idx_q;
  assign class_count = class_count_q;
  assign out_empty   = out_empty_q;
  assign busy        = (state_q != IDLE);

`ifdef SNN_READOUT_TOTAL_EN
  localparam int PW = $clog2(N + 1);

  logic [PW-1:0]      pop;
  logic [TOTAL_W:0]   total_sum;
  logic [TOTAL_W-1:0] total_q;
  logic [TOTAL_W-1:0] total_out_q;

  always_comb begin
    pop = '0;
    for (int n = 0; n < N; n++) pop = pop + PW'(spikes_vec[n]);
  end

  assign total_sum = {1'b0, total_q} + (TOTAL_W + 1)'(pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      total_q     <= '0;
      total_out_q <= '0;
    end else begin
      if (clear) begin
        total_q <= '0;
      end else if (accept) begin
        total_q <= total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
      end
      if (last_scan) total_out_q <= total_q;
    end
  end

  assign total_count = total_out_q;
`else
  assign total_count = '0;
`endif

endmodule : snn_spike_readout

// File: tb/tb_snn_spike_readout.sv
// Scoreboard bench for snn_spike_readout: per-neuron counts are modelled with
// plain integer arrays; a negedge monitor checks each handshaken result.
module tb_snn_spike_readout;

  localparam int N    = 96;
  localparam int CW   = 8;
  localparam int IW   = $clog2(N);
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    int idx;
    int cnt;
    int empty;
    int total;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [15:0]   win_len;
  logic          step_valid;
  logic [N-1:0]  spikes_vec;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] class_idx;
  logic [CW-1:0] class_count;
  logic          out_empty;
  logic          busy;
  logic [15:0]   total_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   mcount[N];
  int   mtotal;

  always #5 clk = ~clk;

  snn_spike_readout #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .win_len     (win_len),
    .step_valid  (step_valid),
    .spikes_vec  (spikes_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .class_idx   (class_idx),
    .class_count (class_count),
    .out_empty   (out_empty),
    .busy        (busy),
    .total_count (total_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    int   sum;
    e.idx = 0;
    e.cnt = 0;
    sum   = 0;
    for (int n = 0; n < N; n++) begin
      sum += mcount[n];
      if (mcount[n] > e.cnt) begin
        e.idx = n;
        e.cnt = mcount[n];
      end
    end
    e.empty = (sum == 0) ? 1 : 0;
`ifdef SNN_READOUT_TOTAL_EN
    e.total = mtotal;
`else
    e.total = 0;
`endif
    return e;
  endfunction

  function automatic logic [N-1:0] rand_vec(input int div);
    logic [N-1:0] v;
    for (int n = 0; n < N; n++) v[n] = ($urandom_range(div - 1, 0) == 0);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_window(input int wl);
    start   = 1'b1;
    win_len = 16'(wl);
    for (int n = 0; n < N; n++) mcount[n] = 0;
    mtotal = 0;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic step(input logic [N-1:0] v, input int gap);
    step_valid = 1'b1;
    spikes_vec = v;
    for (int n = 0; n < N; n++) if (v[n] && mcount[n] < MAXC) mcount[n]++;
    mtotal += $countones(v);
    if (mtotal > 65535) mtotal = 65535;
    tick();
    step_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      spikes_vec = rand_vec(2);
      tick();
    end
  endtask

  // Called right after the final step's edge; checks result latency.
  task automatic end_window(input bit expect_hs);
    int edges;
    edges = 0;
    exp_q.push_back(model_expect());
    while (!out_valid && edges < 4 * N) begin
      tick();
      edges++;
    end
    check("latency", edges, N);
    if (expect_hs) begin
      tick();
      check("idle_after_hs", busy, 0);
      check("valid_low_after_hs", out_valid, 0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn && out_valid && out_ready) begin
      check("sb_pending", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("class_idx", class_idx, e.idx);
        check("class_count", class_count, e.cnt);
        check("out_empty", out_empty, e.empty);
        check("total_count", total_count, e.total);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] v;
    exp_t         e;
    int           wl;

    rstn       = 1'b0;
    start      = 1'b0;
    win_len    = '0;
    step_valid = 1'b0;
    spikes_vec = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_class_idx", class_idx, 0);
    check("rst_class_count", class_count, 0);
    check("rst_out_empty", out_empty, 0);
    check("rst_total", total_count, 0);
    rstn = 1'b1;
    tick();

    // Neuron 5 on all three steps, neuron 7 once.
    begin_window(3);
    v = '0; v[5] = 1'b1; v[7] = 1'b1;
    step(v, 0);
    v[7] = 1'b0;
    step(v, 1);
    step(v, 0);
    end_window(1);

    // Tie between neurons 10 and 20: lowest index wins.
    begin_window(8);
    for (int s = 0; s < 8; s++) begin
      v = '0;
      if (s < 4) v[10] = 1'b1;
      if (s >= 4) v[20] = 1'b1;
      step(v, 0);
    end
    end_window(1);

    // Saturation over a long window.
    begin_window(300);
    for (int s = 0; s < 300; s++) begin
      v = rand_vec(16);
      v[0] = 1'b1;
      step(v, 0);
    end
    end_window(1);

    // Silent window with gaps carrying garbage.
    begin_window(5);
    for (int s = 0; s < 4; s++) step('0, 2);
    step('0, 0);
    end_window(1);

    // Random windows, including win_len 0 (treated as 1).
    for (int w = 0; w < 6; w++) begin
      wl = (w == 0) ? 0 : $urandom_range(12, 1);
      begin_window(wl);
      for (int s = 0; s < ((wl == 0) ? 1 : wl); s++)
        step(rand_vec($urandom_range(16, 2)), (s == wl - 1 || wl == 0) ? 0 : $urandom_range(2, 0));
      end_window(1);
    end

    // Backpressure in DONE with start pulses that must be ignored.
    out_ready = 1'b0;
    begin_window(4);
    for (int s = 0; s < 4; s++) step(rand_vec(4), (s == 3) ? 0 : 1);
    end_window(0);
    e = model_expect();
    for (int c = 0; c < 20; c++) begin
      start   = (c % 5 == 0);
      win_len = 16'd7;
      tick();
      check("bp_hold", (out_valid && busy && class_idx == e.idx && class_count == e.cnt &&
                        out_empty == e.empty && total_count == e.total) ? 1 : 0, 1);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("bp_release_idle", busy, 0);
    check("bp_release_valid", out_valid, 0);
    tick();
    check("bp_no_restart", busy, 0);

    // Asynchronous reset mid-ACCUM, then a clean window.
    begin_window(10);
    v = '0; v[3] = 1'b1; v[40] = 1'b1;
    step(v, 0);
    step(v, 1);
    rstn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_class_idx", class_idx, 0);
    check("arst_class_count", class_count, 0);
    tick();
    rstn = 1'b1;
    tick();
    begin_window(2);
    v = '0; v[3] = 1'b1;
    step(v, 0);
    step(v, 0);
    end_window(1);

    tick();
    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_snn_spike_readout

// File: doc/snn_spike_readout.md
SNN_SPIKE_READOUT -- requirements
Module: snn_spike_readout

Interface
REQ-001 SHALL have parameter N, default 96: number of neurons, equal to the upstream core's spike vector width.
REQ-002 SHALL have parameter CW, default 8: per-neuron spike counter width.
REQ-003 SHALL have ports: clk  in  1  clock; rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: start  in  1  begin a window; win_len  in  16  window length in steps, sampled at start.
REQ-005 SHALL have ports: step_valid  in  1  spikes_vec holds one valid timestep; spikes_vec  in  N  spike bits from the core.
REQ-006 SHALL have ports: out_valid  out  1; out_ready  in  1; class_idx  out  $clog2(N)  winning neuron; class_count  out  CW  its count; out_empty  out  1  no spikes in window; busy  out  1  state not IDLE.
REQ-007 SHALL have port total_count  out  16  total window spikes (see Configuration).

Function
REQ-008 SHALL implement states IDLE, ACCUM, SCAN, DONE; busy = (state != IDLE).
REQ-009 In IDLE, start SHALL clear all N counters, clear the step counter, latch win_len (0 treated as 1), and enter ACCUM at the next edge; start is ignored outside IDLE.
REQ-010 In ACCUM, each step_valid cycle SHALL add spikes_vec[n] to count[n] for all n in parallel, saturating at 2^CW-1, and increment the step counter.
REQ-011 The step_valid cycle completing the latched window length SHALL be accumulated and move the block to SCAN; step_valid gaps SHALL stall without effect; step_valid outside ACCUM is ignored.
REQ-012 SCAN SHALL visit one neuron per cycle, index 0..N-1, replacing the running best only when count > best (strict), so ties resolve to the lowest index.
REQ-013 DONE SHALL be entered after exactly N SCAN cycles; out_valid SHALL assert exactly N edges after the edge sampling the final step.
REQ-014 In DONE, class_idx, class_count, out_empty and total_count SHALL be held stable until out_valid && out_ready, then go to IDLE at that edge.
REQ-015 If all counts are zero, DONE SHALL present class_idx=0, class_count=0, out_empty=1; otherwise out_empty=0.
REQ-016 out_ready SHALL be ignored outside DONE; a same-cycle handshake and start SHALL NOT start a new window (start is sampled only in IDLE).

Reset
REQ-017 rstn low SHALL immediately force state IDLE, out_valid=0, busy=0, class_idx=0, class_count=0, out_empty=0, total_count=0, and clear all counters, including mid-ACCUM or mid-SCAN.
REQ-018 After reset release, the first start SHALL produce counts reflecting only post-reset steps.

Configuration
REQ-019 Macro SNN_READOUT_TOTAL_EN, when defined, SHALL compile in a 16-bit saturating accumulator of the popcount of spikes_vec per accepted step; it is cleared at start and presented on total_count in DONE.
REQ-020 Without SNN_READOUT_TOTAL_EN, total_count SHALL be tied to 0 and no popcount logic SHALL be present.

Structure
REQ-021 Package snn_readout_pkg SHALL hold the state enum type, the default CW, and the 16-bit total-count width constant.
REQ-022 The serial argmax comparator and best-register SHALL be a sub-module, snn_argmax_scan, driven by index, count and a clear signal.

Verification
REQ-023 win_len=3; neuron 5 spikes on all 3 steps, neuron 7 on 1 -> class_idx=5, class_count=3, out_empty=0, out_valid 96 edges after the 3rd step; total_count=4 with the macro, 0 without it.
REQ-024 Tie: neurons 10 and 20 each spike 4 times, win_len=8 -> class_idx=10, class_count=4.
REQ-025 Saturation: win_len=300, neuron 0 spikes every step -> class_count=255.
REQ-026 No spikes, win_len=5 with 2-cycle step_valid gaps -> class_idx=0, class_count=0, out_empty=1.
REQ-027 Backpressure: out_ready low for 20 cycles in DONE, with start pulsed -> outputs stable, no new window; out_ready high -> IDLE next edge.
REQ-028 rstn asserted mid-ACCUM -> busy=0 and out_valid=0 immediately; a new start with win_len=2 and neuron 3 spiking twice -> class_idx=3, class_count=2.
